sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of wdata/rdata in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 3, meaning log2 of storage depth (DEPTH = 2**ADDR_SIZE).
REQ-003 SHALL have parameter AF_LEVEL, default 6, meaning occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, meaning occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port w_inc  input  1  write request.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have port r_inc  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have port count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL accept a write when w_inc=1 and full=0; a write is stored at wr_ptr and wr_ptr increments.
REQ-016 SHALL accept a read when r_inc=1 and empty=0; rd_ptr increments.
REQ-017 SHALL use ADDR_SIZE+1-bit binary pointers, wrapping modulo 2*DEPTH; memory address = low ADDR_SIZE bits.
REQ-018 SHALL update count next edge: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-019 SHALL derive full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL), all reflecting the registered count (no same-cycle request bypass).
REQ-020 SHALL, when full and w_inc=r_inc=1, accept the read and reject the write (count becomes DEPTH-1).
REQ-021 SHALL, when empty and w_inc=r_inc=1, accept the write and reject the read (count becomes 1).
REQ-022 SHALL set overflow on any edge with w_inc=1 and full=1; set underflow on any edge with r_inc=1 and empty=1.
REQ-023 SHALL clear overflow/underflow on clr_err=1; a set condition in the same cycle as clr_err wins (flag stays 1).
REQ-024 SHALL leave rejected requests with no effect on pointers, count or memory.
REQ-025 SHALL require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH; out-of-range settings are illegal configurations.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rdata=0 (registered mode).
REQ-027 SHALL give rst priority over all requests and clr_err; memory contents are not reset.
REQ-028 SHALL discard all stored entries on reset mid-operation; next read after reset returns only data written after reset.

Configuration
REQ-029 SHALL, without SYNC_FIFO_FWFT_EN, register rdata: on an accepted read, rdata loads mem[rd_ptr] at that edge (valid the cycle after r_inc); rdata holds otherwise.
REQ-030 SHALL, with SYNC_FIFO_FWFT_EN defined, drive rdata combinationally from mem[rd_ptr] whenever empty=0 (head visible before r_inc, r_inc pops); rdata value is don't-care when empty=1.
REQ-031 SHALL, in FWFT mode, present a word written into an empty FIFO on rdata the cycle after the write edge (when empty deasserts).

Verification (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, DATA_WIDTH=8)
REQ-032 SHALL cover: rst, write 0x01..0x08 -> count 1..8; almost_empty drops at count 3, almost_full rises at count 6, full at 8; reads return 0x01..0x08 in order, empty=1 after.
REQ-033 SHALL cover: full, w_inc=1 with wdata=0xAA -> overflow=1, count stays 8, 0xAA never read; clr_err pulse -> overflow=0.
REQ-034 SHALL cover: empty, r_inc=1 -> underflow=1, count 0, rdata unchanged (registered mode).
REQ-035 SHALL cover: full, w_inc=r_inc=1 -> count 7, head popped, write rejected; empty, w_inc=r_inc=1 with 0x55 -> count 1, next read returns 0x55.
REQ-036 SHALL cover: 20 writes/reads interleaved at count 4 -> pointers wrap twice, data order preserved, count steady 4.
REQ-037 SHALL cover: rst asserted at count 5 -> next edge count 0, empty=1, flags 0; then write 0x3C and read -> 0x3C; repeat bench with SYNC_FIFO_FWFT_EN checking rdata=0x3C before r_inc.

Source files
------------

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count, watermarks and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through rdata; otherwise rdata is registered.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_inc,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  r_inc,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_SIZE:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(DEPTH);
   localparam logic [ADDR_SIZE:0] AF_CNT   = (ADDR_SIZE+1)'(AF_LEVEL);
   localparam logic [ADDR_SIZE:0] AE_CNT   = (ADDR_SIZE+1)'(AE_LEVEL);
   localparam logic [ADDR_SIZE:0] ONE      = (ADDR_SIZE+1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_SIZE:0]    wr_ptr;
   logic [ADDR_SIZE:0]    rd_ptr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Status flags follow the registered count only, never the same-cycle requests.
   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   assign wr_ok = w_inc & ~full;
   assign rd_ok = r_inc & ~empty;

   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         mem[wr_ptr[ADDR_SIZE-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + ONE;
         if (rd_ok) rd_ptr <= rd_ptr + ONE;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         // A new error in the same cycle as clr_err keeps the flag set.
         if (w_inc && full)  overflow <= 1'b1;
         else if (clr_err)   overflow <= 1'b0;
         if (r_inc && empty) underflow <= 1'b1;
         else if (clr_err)   underflow <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem[rd_ptr[ADDR_SIZE-1:0]];
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (rd_ok) begin
         rdata <= mem[rd_ptr[ADDR_SIZE-1:0]];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized scoreboard bench for sync_fifo against a queue-based model
// Define SYNC_FIFO_FWFT_EN to check first-word-fall-through read timing.
module tb_sync_fifo;

   logic       clk;
   logic       rst;
   logic       w_inc;
   logic [7:0] wdata;
   logic       r_inc;
   logic       clr_err;
   logic [7:0] rdata;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq[$];     // model contents, updated at each edge
   logic [7:0] sb_q[$];   // scoreboard of words expected at the read port
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;
   logic [7:0] m_rdata = 8'h00;
   logic       pend = 1'b0;

   sync_fifo #(.DATA_WIDTH(8), .ADDR_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .w_inc(w_inc), .wdata(wdata), .r_inc(r_inc),
      .clr_err(clr_err), .rdata(rdata), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT performs a read.
   always @(negedge clk) begin
      logic [7:0] e;
`ifdef SYNC_FIFO_FWFT_EN
      if (!rst && r_inc && !empty) begin
         if (sb_q.size() == 0) chk("sb_underrun", 1, 0);
         else begin
            e = sb_q.pop_front();
            chk("rd_data_fwft", {24'h0, rdata}, {24'h0, e});
         end
      end
`else
      if (pend) begin
         if (sb_q.size() == 0) chk("sb_underrun", 1, 0);
         else begin
            e = sb_q.pop_front();
            chk("rd_data", {24'h0, rdata}, {24'h0, e});
         end
      end
      pend = !rst && r_inc && !empty;
`endif
   end

   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
      int  n;
      logic wacc, racc, was_full, was_empty;
      w_inc = w; wdata = d; r_inc = r; clr_err = c; rst = rs;
      n = mq.size();
      was_full  = (n == 8);
      was_empty = (n == 0);
      wacc = w && !was_full && !rs;
      racc = r && !was_empty && !rs;
      if (wacc) sb_q.push_back(d);
      @(posedge clk);
      #1;
      if (rs) begin
         mq.delete();
         sb_q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
      end else begin
         if (racc) m_rdata = mq.pop_front();
         if (wacc) mq.push_back(d);
         if (w && was_full) m_ovf = 1'b1;
         else if (c)        m_ovf = 1'b0;
         if (r && was_empty) m_udf = 1'b1;
         else if (c)         m_udf = 1'b0;
      end
      n = mq.size();
      chk("count", {28'h0, count}, n);
      chk("full", {31'h0, full}, {31'h0, n == 8});
      chk("empty", {31'h0, empty}, {31'h0, n == 0});
      chk("almost_full", {31'h0, almost_full}, {31'h0, n >= 6});
      chk("almost_empty", {31'h0, almost_empty}, {31'h0, n <= 2});
      chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
      chk("underflow", {31'h0, underflow}, {31'h0, m_udf});
`ifdef SYNC_FIFO_FWFT_EN
      if (n > 0) chk("head_visible", {24'h0, rdata}, {24'h0, mq[0]});
`else
      chk("rdata_hold", {24'h0, rdata}, {24'h0, m_rdata});
`endif
   endtask

   initial begin
      rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 1);

      // fill 0x01..0x08, overflow attempt, clear
      for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0, 0);
      cyc(1, 8'hAA, 0, 0, 0);
      cyc(0, 8'h00, 0, 1, 0);
      // overflow set and clear in the same cycle: set wins
      cyc(1, 8'hAA, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 1, 0);

      // simultaneous requests at full and at empty
      for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
      cyc(1, 8'hEE, 1, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(1, 8'h55, 1, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);

      // steady occupancy 4 with pointer wrap
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 8'(8'h40 + i), 1, 0, 0);

      // reset mid-operation at count 5
      cyc(1, 8'h77, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);
      cyc(1, 8'h3C, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 100) < 55, 8'($urandom), ($urandom % 100) < 50,
             ($urandom % 16) == 0, ($urandom % 97) == 0);
      end
      cyc(0, 8'h00, 0, 0, 0);
      chk("sb_drained", sb_q.size(), mq.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
